jellyvl_time_counter: RTL
=========================

// Module: jellyvl_time_counter
// PURPOSE
//  Local time base. Produces the free-running current_time bus consumed by jellyvl_periodic_trigger and similar stages.
//  Each enabled cycle it adds a fixed-point step (integer + fraction). It supports an absolute set and a signed offset.
//  The offset is slewed gradually, so time never runs backwards while slewing.
// PARAMETERS
//  TIMER_WIDTH  64  integer width of current_time
//  FRAC_WIDTH   16  fractional bits of the internal accumulator
//  STEP_WIDTH   32  width of step / slew_limit (unsigned fixed point, FRAC_WIDTH fraction bits)
//  ADJ_WIDTH    32  width of adj_value (signed, integer time units)
// PORTS
//  clk           in   1            clock
//  rst_n         in   1            asynchronous reset, active-low
//  enable        in   1            1: count and slew; 0: accumulator and slew state hold
//  step          in   STEP_WIDTH   per-cycle increment, fixed point
//  slew_limit    in   STEP_WIDTH   maximum per-cycle correction magnitude, fixed point
//  set_valid     in   1            absolute set request
//  set_ready     out  1            always 1 (set accepted every cycle)
//  set_time      in   TIMER_WIDTH  value to load
//  adj_valid     in   1            offset request
//  adj_ready     out  1            = (state==IDLE) && !set_valid
//  adj_value     in   ADJ_WIDTH    signed offset, integer units
//  busy          out  1            1 while state==SLEW
//  current_time  out  TIMER_WIDTH  registered integer part of the accumulator
// BEHAVIOUR
//  - Accumulator acc: TIMER_WIDTH+FRAC_WIDTH bits, unsigned; current_time = acc[MSB:FRAC_WIDTH].
//  - Arithmetic is modulo 2^(TIMER_WIDTH+FRAC_WIDTH). Wrap-around is silent, with no flag.
//  - Reset: acc=0, remaining=0, state=IDLE, so current_time=0 and busy=0.
//    adj_ready follows its equation (1 when set_valid=0).
//  - Set: set_valid sampled at edge N gives current_time==set_time after N, with fraction cleared.
//    Increment resumes at N+1 if enable=1. Step is not added in the set cycle.
//  - Priority: set > adjust > normal count.
//    A set during SLEW aborts the slew: remaining=0, state=IDLE.
//    An adjust presented together with a set is not accepted (adj_ready=0).
//  - Adjust handshake: accepted when adj_valid && adj_ready at edge N.
//    remaining <= adj_value << FRAC_WIDTH (sign-extended). State becomes SLEW if adj_value!=0.
//    adj_value==0 is accepted with no state change.
//  - SLEW (per enabled cycle):
//    - rem>0: corr = min(rem, slew_limit); acc += step + corr; rem -= corr.
//    - rem<0: corr = min(-rem, slew_limit, step); acc += step - corr; rem += corr.
//      Increment is >= 0, so current_time stays monotonic.
//    - The cycle rem reaches 0: state becomes IDLE, busy=0, adj_ready=1 from the next cycle.
//    - slew_limit==0 means no progress; state stays SLEW until a set or reset.
//  - IDLE: acc += step when enable=1.
//  - enable=0: acc, rem and state hold. Set is still honoured. Adjust is still accepted (rem loaded, state may go SLEW).
//  - step and slew_limit are sampled every cycle and may change at any time.
//  - Reset mid-slew: everything returns to reset values immediately (asynchronous).
// CONFIGURATION
//  JELLYVL_TIME_COUNTER_SLEW_EN
//  - Defined: slewing as above.
//  - Undefined: the offset is applied in one cycle.
//    - Accept at N gives acc += step + (adj_value<<FRAC_WIDTH) at N (time may step backwards).
//    - State is always IDLE: busy=0, slew_limit ignored, adj_ready = !set_valid.
// TESTING
//  Common setup: FRAC_WIDTH=16, step=0x10000 (1.0), enable=1.
//  1 Reset release -> current_time 0,1,2,3 on successive cycles; busy=0; adj_ready=1.
//  2 step=0x18000 (1.5) from 0 -> current_time 0,1,3,4,6 (fraction carries correctly).
//  3 set_time=0xFFFF_FFFF_FFFF_FFFE -> ...FFFE, ...FFFF, 0, 1 (wrap, no glitch).
//  4 SLEW_EN, slew_limit=0x8000, adj_value=+2 at time 10
//    -> +1.5/cycle for 4 cycles, then busy=0; time 16 after 4 cycles; adj_ready=0 meanwhile.
//  5 SLEW_EN, slew_limit=0x20000, adj_value=-3 -> increment 0 for 3 cycles (time held), then +1; never decreases.
//  6 Set asserted with adj_valid mid-slew -> set_time loaded, busy=0 next cycle, adjust not accepted.
//    Without SLEW_EN, adj_value=-5 at time 20 -> next value 16.

Source files
------------

// File: rtl/jellyvl_time_counter_if.sv
// ----------------------------------------------------------------------------
// jellyvl_time_counter_if
//   Bundles the control, request/response and time outputs of
//   jellyvl_time_counter.
//
//   Handshake rule (set_* and adj_*): a request transfers on a rising clock
//   edge where valid && ready are both 1. valid may be raised at any time.
//   The requester keeps its payload stable while valid is high and ready is
//   low. ready may depend combinationally on valid in the same cycle. It
//   never depends on the payload.
//
//   master : time consumer/controller (drives enable, step, slew_limit,
//            set_*, adj_*; observes ready flags, busy, current_time)
//   slave  : jellyvl_time_counter
// ----------------------------------------------------------------------------
interface jellyvl_time_counter_if #(
    parameter int TIMER_WIDTH = 64,
    parameter int STEP_WIDTH  = 32,
    parameter int ADJ_WIDTH   = 32
);
    logic                        enable;
    logic [STEP_WIDTH-1:0]       step;
    logic [STEP_WIDTH-1:0]       slew_limit;
    logic                        set_valid;
    logic                        set_ready;
    logic [TIMER_WIDTH-1:0]      set_time;
    logic                        adj_valid;
    logic                        adj_ready;
    logic signed [ADJ_WIDTH-1:0] adj_value;
    logic                        busy;
    logic [TIMER_WIDTH-1:0]      current_time;

    modport master (
        output enable, step, slew_limit,
        output set_valid, set_time, adj_valid, adj_value,
        input  set_ready, adj_ready, busy, current_time
    );

    modport slave (
        input  enable, step, slew_limit,
        input  set_valid, set_time, adj_valid, adj_value,
        output set_ready, adj_ready, busy, current_time
    );
endinterface

// File: rtl/jellyvl_time_counter.sv
// ----------------------------------------------------------------------------
// jellyvl_time_counter
//   Free-running local time base. Each enabled cycle a fixed-point step
//   (FRAC_WIDTH fraction bits) is added to an internal accumulator. The
//   integer part of the accumulator is current_time. The block supports an
//   absolute set and a signed offset adjustment. The priority order is
//   set > adjust > count.
//
//   Build option JELLYVL_TIME_COUNTER_SLEW_EN:
//     defined   : the offset is slewed in over several cycles, bounded by
//                 slew_limit. Time never decreases while slewing.
//     undefined : the offset is added in the accept cycle. Time may jump
//                 backwards. busy is always 0 and slew_limit is unused.
//
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : jellyvl_time_counter_if.slave
//                  (enable, step, slew_limit, set_*, adj_*, busy,
//                   current_time)
// ----------------------------------------------------------------------------
module jellyvl_time_counter #(
    parameter int TIMER_WIDTH = 64,
    parameter int FRAC_WIDTH  = 16,
    parameter int STEP_WIDTH  = 32,
    parameter int ADJ_WIDTH   = 32
) (
    input logic                    clk,
    input logic                    rst_n,
    jellyvl_time_counter_if.slave  bus
);
    localparam int ACC_W = TIMER_WIDTH + FRAC_WIDTH;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] step_acc;
    logic [ACC_W-1:0] set_acc;

    assign step_acc         = ACC_W'(bus.step);
    assign set_acc          = {bus.set_time, {FRAC_WIDTH{1'b0}}};
    assign bus.set_ready    = 1'b1;
    assign bus.current_time = acc_q[ACC_W-1:FRAC_WIDTH];

`ifdef JELLYVL_TIME_COUNTER_SLEW_EN
    // One spare bit keeps the negation of the most negative offset in range.
    localparam int REM_W = ADJ_WIDTH + FRAC_WIDTH + 1;
    localparam int CW    = (REM_W > STEP_WIDTH) ? REM_W : STEP_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        SLEW = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic signed [REM_W-1:0]  rem_q, rem_d;
    logic signed [REM_W-1:0]  adj_rem;
    logic [CW-1:0]            rem_mag;
    logic [CW-1:0]            limit_cw;
    logic [CW-1:0]            step_cw;
    logic [CW-1:0]            corr;
    logic [ACC_W-1:0]         corr_acc;

    assign adj_rem  = {bus.adj_value[ADJ_WIDTH-1], bus.adj_value, {FRAC_WIDTH{1'b0}}};
    assign rem_mag  = rem_q[REM_W-1] ? CW'($unsigned(-rem_q)) : CW'($unsigned(rem_q));
    assign limit_cw = CW'(bus.slew_limit);
    assign step_cw  = CW'(bus.step);
    assign corr_acc = ACC_W'(corr);

    // Negative corrections are also capped by step so the net increment
    // never goes below zero.
    always_comb begin
        corr = (rem_mag < limit_cw) ? rem_mag : limit_cw;
        if (rem_q[REM_W-1] && (step_cw < corr)) begin
            corr = step_cw;
        end
    end

    always_comb begin
        acc_d   = acc_q;
        rem_d   = rem_q;
        state_d = state_q;
        if (bus.set_valid) begin
            acc_d   = set_acc;
            rem_d   = '0;
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (bus.enable) begin
                acc_d = acc_q + step_acc;
            end
            // In IDLE with no set, adj_ready is 1, so valid alone accepts.
            if (bus.adj_valid) begin
                rem_d   = adj_rem;
                state_d = (adj_rem != '0) ? SLEW : IDLE;
            end
        end else if (bus.enable) begin
            if (rem_q[REM_W-1]) begin
                acc_d = acc_q + step_acc - corr_acc;
                rem_d = rem_q + REM_W'(corr);
            end else begin
                acc_d = acc_q + step_acc + corr_acc;
                rem_d = rem_q - REM_W'(corr);
            end
            if (rem_d == '0) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            rem_q   <= '0;
            state_q <= IDLE;
        end else begin
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            state_q <= state_d;
        end
    end

    assign bus.adj_ready = (state_q == IDLE) && !bus.set_valid;
    assign bus.busy      = (state_q == SLEW);
`else
    logic [ACC_W-1:0] adj_acc;
    logic             unused_slew_limit;

    assign adj_acc = {{(TIMER_WIDTH-ADJ_WIDTH){bus.adj_value[ADJ_WIDTH-1]}},
                      bus.adj_value, {FRAC_WIDTH{1'b0}}};
    assign unused_slew_limit = ^bus.slew_limit;

    always_comb begin
        acc_d = acc_q;
        if (bus.set_valid) begin
            acc_d = set_acc;
        end else begin
            if (bus.enable) begin
                acc_d = acc_d + step_acc;
            end
            if (bus.adj_valid) begin
                acc_d = acc_d + adj_acc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign bus.adj_ready = !bus.set_valid;
    assign bus.busy      = 1'b0;
`endif
endmodule
